// File: rtl/mc14500_pkg.sv
// Shared opcode map, execute-action encoding and ROM word field helpers
// for the mc14500b ICU and its program sequencer.
package mc14500_pkg;

  localparam int unsigned MAX_ADDR_W = 32;
  localparam int unsigned WORD_MAX_W = MAX_ADDR_W + 4;

  typedef logic [WORD_MAX_W-1:0] word_max_t;
  typedef logic [MAX_ADDR_W-1:0] opnd_max_t;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  // What the sequencer does to the PC / stack at an execute edge.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_CALL,
    ACT_RET,
    ACT_RESTART,
    ACT_HALT
  } seq_action_e;

  // Words are zero-extended to the widest supported width before slicing.
  function automatic logic [3:0] op_of(input word_max_t word, input int unsigned addr_w);
    return 4'(word >> addr_w);
  endfunction

  function automatic opnd_max_t opnd_of(input word_max_t word, input int unsigned addr_w);
    word_max_t mask;
    mask = ~(word_max_t'(4'hF) << addr_w);
    return MAX_ADDR_W'(word & mask);
  endfunction

endpackage

// File: rtl/mc14500_ret_stack.sv
// Return-address LIFO for the sequencer: push, pop and clear, with
// full/empty status, occupancy and a combinational view of the top entry.
module mc14500_ret_stack #(
  parameter int unsigned STK_D  = 4,
  parameter int unsigned ADDR_W = 8,
  localparam int unsigned DEP_W = $clog2(STK_D + 1)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DEP_W-1:0]  depth,
  output logic [ADDR_W-1:0] top
);

  localparam int unsigned IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

  logic [ADDR_W-1:0] mem [STK_D];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign full   = (depth == DEP_W'(STK_D));
  assign empty  = (depth == '0);
  assign wr_idx = IDX_W'(depth);
  assign rd_idx = IDX_W'(depth - DEP_W'(1));
  assign top    = empty ? '0 : mem[rd_idx];

  // Occupancy: clear beats push/pop; overflowing pushes and empty pops are ignored.
  always_ff @(posedge clk_in) begin
    if (!rst || clear) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DEP_W'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEP_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst && push && !full && !clear) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/mc14500_sequencer.sv
// Program sequencer and 1-bit I/O back end for the mc14500b ICU: owns the PC,
// acts on JMP/RTN/NOPO/NOPF at execute edges, and serves the ICU data bus.
module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned IO_W            = 3,
  parameter int unsigned STK_D           = 4,
  parameter bit          HALT_ON_NOPF    = 1'b1,
  parameter bit          RESTART_ON_NOPO = 1'b1,
  localparam int unsigned IO_N  = 2 ** IO_W,
  localparam int unsigned DEP_W = $clog2(STK_D + 1)
) (
  input  logic                clk_in,
  input  logic                rst,
  output logic [ADDR_W-1:0]   pc_o,
  input  logic [ADDR_W+3:0]   rom_data,
  output logic [3:0]          I,
  input  logic                state_in,
  input  logic                skp_in,
  input  logic                jmp_in,
  input  logic                rtn_in,
  input  logic                write_in,
  inout  wire                 data,
  input  logic [IO_N-1:0]     in_pins,
  output logic [IO_N-1:0]     out_pins,
  output logic                halted,
  output logic                stk_err,
  output logic                seq_err,
  output logic [DEP_W-1:0]    stk_depth
);

  word_max_t         rom_word;
  logic [ADDR_W-1:0] fetch_opnd;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] opnd_q;
  logic              skip_q;
  logic              did_jmp;
  logic              did_rtn;
  logic [IO_W-1:0]   io_sel;

  seq_action_e       action;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              push;
  logic              pop;
  logic              clear;
  logic              halt_set;
  logic              stk_err_set;
  logic              seq_err_set;

  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;

  assign rom_word   = word_max_t'(rom_data);
  assign I          = op_of(rom_word, ADDR_W);
  assign fetch_opnd = ADDR_W'(opnd_of(rom_word, ADDR_W));
  assign pc_inc     = pc_o + ADDR_W'(1);
  assign io_sel     = opnd_q[IO_W-1:0];

  // The ICU owns the bus while it stores; otherwise it reads the selected input.
  assign data = write_in ? 1'bz : in_pins[io_sel];

  mc14500_ret_stack #(
    .STK_D  (STK_D),
    .ADDR_W (ADDR_W)
  ) u_stack (
    .clk_in (clk_in),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .clear  (clear),
    .din    (pc_inc),
    .full   (stk_full),
    .empty  (stk_empty),
    .depth  (stk_depth),
    .top    (stk_top)
  );

  // Execute-edge decode of the latched word; priority halted > skip > opcode.
  always_comb begin
    action = ACT_HOLD;
    if (state_in && !halted) begin
      if (skip_q) begin
        action = ACT_STEP;
      end else begin
        case (op_q)
          OP_JMP:  action = ACT_CALL;
          OP_RTN:  action = ACT_RET;
          OP_NOPO: action = RESTART_ON_NOPO ? ACT_RESTART : ACT_STEP;
          OP_NOPF: action = HALT_ON_NOPF ? ACT_HALT : ACT_STEP;
          default: action = ACT_STEP;
        endcase
      end
    end
  end

  // PC, stack controls and sticky-flag set terms for the chosen action.
  always_comb begin
    pc_next     = pc_o;
    push        = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;
    halt_set    = 1'b0;
    stk_err_set = 1'b0;
    case (action)
      ACT_STEP: pc_next = pc_inc;
      ACT_CALL: begin
        pc_next     = opnd_q;
        push        = !stk_full;
        stk_err_set = stk_full;
      end
      ACT_RET: begin
        pc_next     = stk_empty ? '0 : stk_top;
        pop         = !stk_empty;
        stk_err_set = stk_empty;
      end
      ACT_RESTART: begin
        pc_next = '0;
        clear   = 1'b1;
      end
      ACT_HALT: halt_set = 1'b1;
      default: ;
    endcase
  end

  // A JMP/RTN flag in a fetch cycle must follow an executed JMP/RTN.
  always_comb begin
    seq_err_set = !state_in && ((jmp_in && !did_jmp) || (rtn_in && !did_rtn));
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      pc_o     <= '0;
      op_q     <= OP_NOPO;
      opnd_q   <= '0;
      skip_q   <= 1'b0;
      did_jmp  <= 1'b0;
      did_rtn  <= 1'b0;
      halted   <= 1'b0;
      stk_err  <= 1'b0;
      seq_err  <= 1'b0;
      out_pins <= '0;
    end else begin
      pc_o <= pc_next;
      if (!state_in) begin
        op_q   <= I;
        opnd_q <= fetch_opnd;
        skip_q <= skp_in;
      end else begin
        did_jmp <= (action == ACT_CALL);
        did_rtn <= (action == ACT_RET);
      end
      if (halt_set) halted <= 1'b1;
      if (stk_err_set) stk_err <= 1'b1;
      if (seq_err_set) seq_err <= 1'b1;
      // Store lands using the STO operand still held in opnd_q.
      if (write_in) out_pins[io_sel] <= data;
    end
  end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Bench for mc14500_sequencer: a small ICU stand-in drives the handshake, an
// instruction-level model predicts PC/stack/I-O state, and directed checks pin it.
module tb_mc14500_sequencer;
  import mc14500_pkg::*;

  localparam int unsigned STK_D = 4;

  logic        clk_in;
  logic        rst;
  logic [7:0]  pc_o;
  logic [11:0] rom [256];
  wire  [11:0] rom_data;
  logic [3:0]  I;
  logic [7:0]  in_pins;
  logic [7:0]  out_pins;
  logic        halted, stk_err, seq_err;
  logic [2:0]  stk_depth;
  wire         data;

  // ICU stand-in state
  logic       st, skp_pend, rr, wr, jf, rf, dout, irskip, inj;
  logic [3:0] ir;

  // narrow-address instance used for the wrap check
  logic [3:0] pc_w;
  wire  [7:0] rom_w;
  logic [3:0] i_w;
  logic [7:0] out_w;
  logic       h_w, se_w, qe_w;
  logic [2:0] dep_w;
  wire        data_w;

  int total = 0;
  int bad   = 0;

  // instruction-level model
  logic [7:0] m_pc, m_out;
  logic       m_rr, m_skip, m_halt, m_stk_err, m_seq_err;
  logic [7:0] m_stk [$];
  int unsigned w_cnt;

  assign rom_data = rom[pc_o];
  assign rom_w    = {OP_OR, 4'h0};
  assign data     = wr ? dout : 1'bz;

  mc14500_sequencer #(.ADDR_W(8), .IO_W(3), .STK_D(STK_D)) dut (
    .clk_in(clk_in), .rst(rst), .pc_o(pc_o), .rom_data(rom_data), .I(I),
    .state_in(st), .skp_in(skp_pend), .jmp_in(jf), .rtn_in(rf | inj), .write_in(wr),
    .data(data), .in_pins(in_pins), .out_pins(out_pins), .halted(halted),
    .stk_err(stk_err), .seq_err(seq_err), .stk_depth(stk_depth)
  );

  mc14500_sequencer #(.ADDR_W(4), .IO_W(3), .STK_D(STK_D)) dut_w (
    .clk_in(clk_in), .rst(rst), .pc_o(pc_w), .rom_data(rom_w), .I(i_w),
    .state_in(st), .skp_in(1'b0), .jmp_in(1'b0), .rtn_in(1'b0), .write_in(1'b0),
    .data(data_w), .in_pins(in_pins), .out_pins(out_w), .halted(h_w),
    .stk_err(se_w), .seq_err(qe_w), .stk_depth(dep_w)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ICU stand-in: alternates fetch/execute, flags JMP/RTN and stores for one fetch cycle.
  always @(posedge clk_in) begin
    if (!rst) begin
      st <= 1'b0; skp_pend <= 1'b0; rr <= 1'b0; wr <= 1'b0; jf <= 1'b0; rf <= 1'b0;
      dout <= 1'b0; ir <= OP_NOPO; irskip <= 1'b0;
    end else if (!st) begin
      st <= 1'b1; ir <= I; irskip <= skp_pend; wr <= 1'b0; jf <= 1'b0; rf <= 1'b0;
    end else begin
      st <= 1'b0; skp_pend <= 1'b0; wr <= 1'b0; jf <= 1'b0; rf <= 1'b0;
      if (!irskip) begin
        case (ir)
          OP_LD:   rr <= data;
          OP_LDC:  rr <= ~data;
          OP_OR:   rr <= rr | data;
          OP_STO:  begin wr <= 1'b1; dout <= rr; end
          OP_STOC: begin wr <= 1'b1; dout <= ~rr; end
          OP_SKZ:  skp_pend <= ~rr;
          OP_JMP:  jf <= 1'b1;
          OP_RTN:  begin rf <= 1'b1; skp_pend <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  task automatic model_exec();
    logic [11:0] w;
    logic [7:0]  a;
    logic [7:0]  nxt;
    logic        d;
    if (m_halt) return;
    w   = rom[m_pc];
    a   = w[7:0];
    d   = in_pins[a[2:0]];
    nxt = m_pc + 8'd1;
    if (m_skip) begin
      m_skip = 1'b0;
      m_pc   = nxt;
      return;
    end
    m_skip = 1'b0;
    m_pc   = nxt;
    case (w[11:8])
      OP_LD:   m_rr = d;
      OP_LDC:  m_rr = ~d;
      OP_OR:   m_rr = m_rr | d;
      OP_STO:  m_out[a[2:0]] = m_rr;
      OP_STOC: m_out[a[2:0]] = ~m_rr;
      OP_SKZ:  m_skip = ~m_rr;
      OP_JMP: begin
        if (m_stk.size() < STK_D) m_stk.push_back(nxt);
        else m_stk_err = 1'b1;
        m_pc = a;
      end
      OP_RTN: begin
        if (m_stk.size() == 0) begin
          m_pc = 8'd0;
          m_stk_err = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
        m_skip = 1'b1;
      end
      OP_NOPO: begin m_pc = 8'd0; m_stk.delete(); end
      OP_NOPF: begin m_halt = 1'b1; m_pc = nxt - 8'd1; end
      default: ;
    endcase
  endtask

  // Model advances once per instruction, at the execute edge.
  initial begin
    forever begin
      @(posedge clk_in);
      if (!rst) begin
        m_pc = 8'd0; m_out = 8'd0; m_rr = 1'b0; m_skip = 1'b0; m_halt = 1'b0;
        m_stk_err = 1'b0; m_seq_err = 1'b0; m_stk.delete(); w_cnt = 0;
      end else begin
        if (inj && !st) m_seq_err = 1'b1;
        if (st) begin
          model_exec();
          w_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // In every execute cycle all effects of earlier instructions are visible.
  always @(negedge clk_in) begin
    if (rst && st === 1'b1) begin
      check("pc", 32'(pc_o), 32'(m_pc));
      check("opcode", 32'(I), 32'(rom[m_pc][11:8]));
      check("depth", 32'(stk_depth), 32'(m_stk.size()));
      check("out_pins", 32'(out_pins), 32'(m_out));
      check("halted", 32'(halted), 32'(m_halt));
      check("stk_err", 32'(stk_err), 32'(m_stk_err));
      check("seq_err", 32'(seq_err), 32'(m_seq_err));
      check("wrap_pc", 32'(pc_w), 32'(w_cnt % 16));
      check("wrap_out", 32'(out_w), 32'(0));
      check("wrap_flags", 32'({h_w, se_w, qe_w, i_w}), 32'({3'b000, OP_OR}));
      check("wrap_depth", 32'(dep_w), 32'(0));
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {OP_OR, 8'h00};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
  endtask

  task automatic wait_pc(input logic [7:0] target, input string name);
    int n;
    n = 0;
    while (pc_o !== target && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check(name, 32'(pc_o), 32'(target));
  endtask

  task automatic check_final(input string name, input logic [7:0] pc, input logic [7:0] outs,
                             input logic [2:0] dep, input logic [2:0] flags);
    check({name, "_pc"}, 32'(pc_o), 32'(pc));
    check({name, "_out"}, 32'(out_pins), 32'(outs));
    check({name, "_depth"}, 32'(stk_depth), 32'(dep));
    check({name, "_flags"}, 32'({halted, stk_err, seq_err}), 32'(flags));
  endtask

  initial begin
    rst = 1'b0;
    inj = 1'b0;
    in_pins = 8'h00;

    // Straight line: reset state, then PC steps every two clocks.
    clear_rom();
    in_pins = 8'h01;
    rom[0] = {OP_LD, 8'd0}; rom[1] = {OP_STO, 8'd1}; rom[2] = {OP_STO, 8'd3}; rom[3] = {OP_NOPF, 8'd0};
    repeat (2) @(negedge clk_in);
    check_final("reset", 8'd0, 8'h00, 3'd0, 3'b000);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("line_step", 32'(pc_o), 32'(k));
      @(negedge clk_in);
    end
    repeat (6) @(negedge clk_in);
    check_final("line", 8'd3, 8'h0A, 3'd0, 3'b100);

    // I/O: LD 5; STO 2; NOPF with in_pins=0x20.
    clear_rom();
    in_pins = 8'h20;
    rom[0] = {OP_LD, 8'd5}; rom[1] = {OP_STO, 8'd2}; rom[2] = {OP_NOPF, 8'd0};
    do_reset();
    repeat (4) @(negedge clk_in);
    check("io_before_store", 32'(out_pins), 32'(8'h00));
    @(negedge clk_in);
    check("io_after_store", 32'(out_pins), 32'(8'h04));
    repeat (8) @(negedge clk_in);
    check_final("io", 8'd2, 8'h04, 3'd0, 3'b100);

    // Call/return with a filler word after the call site.
    clear_rom();
    in_pins = 8'h01;
    rom[0] = {OP_LD, 8'd0}; rom[3] = {OP_JMP, 8'h40}; rom[4] = {OP_STO, 8'd7};
    rom[5] = {OP_STO, 8'd6}; rom[6] = {OP_NOPF, 8'd0}; rom[8'h40] = {OP_RTN, 8'd0};
    do_reset();
    wait_pc(8'h40, "call_target");
    check("call_depth", 32'(stk_depth), 32'(1));
    wait_pc(8'h04, "return_addr");
    check("return_depth", 32'(stk_depth), 32'(0));
    repeat (12) @(negedge clk_in);
    check_final("callret", 8'd6, 8'h40, 3'd0, 3'b100);

    // Overflow: five nested calls into a four-deep stack.
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {OP_JMP, 8'(i + 1)};
    rom[5] = {OP_NOPF, 8'd0};
    do_reset();
    repeat (16) @(negedge clk_in);
    check_final("overflow", 8'd5, 8'h00, 3'd4, 3'b110);

    // Underflow: RTN on empty stack goes to 0, then that word is skipped.
    clear_rom();
    rom[0] = {OP_RTN, 8'd0}; rom[1] = {OP_NOPF, 8'd0};
    do_reset();
    repeat (10) @(negedge clk_in);
    check_final("underflow", 8'd1, 8'h00, 3'd0, 3'b110);

    // SKZ with RR=0 skips the JMP.
    clear_rom();
    in_pins = 8'h00;
    rom[0] = {OP_LD, 8'd0}; rom[1] = {OP_SKZ, 8'd0}; rom[2] = {OP_JMP, 8'h10};
    rom[3] = {OP_NOPF, 8'd0}; rom[8'h10] = {OP_NOPF, 8'd0};
    do_reset();
    repeat (12) @(negedge clk_in);
    check_final("skz", 8'd3, 8'h00, 3'd0, 3'b100);

    // Reset asserted in the execute cycle of a JMP.
    clear_rom();
    rom[0] = {OP_RTN, 8'd0}; rom[1] = {OP_JMP, 8'h20};
    rom[8'h20] = {OP_JMP, 8'h30}; rom[8'h30] = {OP_NOPF, 8'd0};
    do_reset();
    wait_pc(8'h20, "pre_reset_pc");
    @(negedge clk_in);
    check("pre_reset_state", 32'({st, stk_err, stk_depth}), 32'({1'b1, 1'b1, 3'd1}));
    rst = 1'b0;
    @(negedge clk_in);
    check_final("mid_reset", 8'd0, 8'h00, 3'd0, 3'b000);
    rst = 1'b1;
    wait_pc(8'h30, "rerun_pc");
    repeat (6) @(negedge clk_in);

    // Spurious RTN flag from the ICU sets seq_err.
    check("seq_err_clean", 32'(seq_err), 32'(0));
    if (st) @(negedge clk_in);
    inj = 1'b1;
    @(negedge clk_in);
    inj = 1'b0;
    @(negedge clk_in);
    check_final("seq_err", 8'h30, 8'h00, 3'd2, 3'b111);

    // Wrap: the 4-bit instance rolls 15 -> 0 while the 8-bit one reaches 16.
    clear_rom();
    do_reset();
    repeat (31) @(negedge clk_in);
    check("wrap_at_15", 32'({pc_w, pc_o}), 32'({4'd15, 8'd15}));
    repeat (2) @(negedge clk_in);
    check("wrap_to_0", 32'({pc_w, pc_o}), 32'({4'd0, 8'd16}));

    repeat (2) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc14500_sequencer.md
# mc14500_sequencer

Program sequencer and I/O back end for the mc14500b ICU core. It owns the program counter, which addresses an asynchronous-read program ROM, and feeds the opcode nibble to the ICU's `I` input. It acts on JMP/RTN/NOPO/NOPF with zero delay slots by decoding the fetched word in step with the ICU's two-phase cycle. It also serves the ICU's 1-bit data bus from an addressable input mux and an addressable output latch.

## Interface
- `ADDR_W`, 8: program address width; jump operand width.
- `IO_W`, 3: I/O select width; `IO_N = 2**IO_W` inputs and outputs.
- `STK_D`, 4: return-stack depth, ≥1.
- `HALT_ON_NOPF`, 1: NOPF freezes the PC.
- `RESTART_ON_NOPO`, 1: NOPO restarts at address 0.

Ports:
- `clk_in`  in  1  clock. Same clock as the ICU.
- `rst`  in  1  reset, synchronous, active-low.
- `pc_o`  out  ADDR_W  ROM address.
- `rom_data`  in  4+ADDR_W  ROM word, valid in the same cycle as `pc_o`. Bits `[ADDR_W+3:ADDR_W]` are the opcode; bits `[ADDR_W-1:0]` are the operand.
- `I`  out  4  opcode to the ICU, equal to `rom_data` opcode bits (combinational).
- `state_in`, `skp_in`, `jmp_in`, `rtn_in`, `write_in`  in  1 each  from ICU `state_out`, `SKP`, `JMP`, `RTN`, `write`.
- `data`  inout  1  ICU data bus. The sequencer drives it only while `write_in==0`.
- `in_pins`  in  IO_N  external inputs.
- `out_pins`  out  IO_N  output latch.
- `halted`, `stk_err`, `seq_err`  out  1 each  status flags, all sticky.
- `stk_depth`  out  $clog2(STK_D+1)  stack occupancy.

## Operation
- Opcodes match the ICU: JMP=1100, RTN=1101, NOPO=0000, NOPF=1111.
- **Fetch edge** (posedge with `state_in==0`):
  - Capture `op_q`, `opnd_q` from `rom_data`.
  - Capture `skip_q = skp_in`. A skipped word is latched but never acted on.
- **Execute edge** (posedge with `state_in==1`), first match wins:
  - `halted` set: PC holds.
  - `skip_q`: `pc<=pc+1`.
  - JMP: push `pc+1`, then `pc<=opnd_q`. If the stack is full, the push is dropped, the jump is still taken, and `stk_err` is set.
  - RTN: pop into `pc`. If the stack is empty, `pc<=0` and `stk_err` is set. The ICU then skips the word at the popped address, so the matching call site must be followed by a filler word.
  - NOPO with `RESTART_ON_NOPO`: `pc<=0` and the stack is cleared.
  - NOPF with `HALT_ON_NOPF`: `halted<=1` and PC holds.
  - Otherwise: `pc<=pc+1`.
  - PC arithmetic wraps modulo 2^ADDR_W.
- **Input path**:
  - While `write_in==0`, drive `data = in_pins[opnd_q[IO_W-1:0]]`.
  - While `write_in==1`, `data` is high-Z.
- **Output path**:
  - On any posedge with `write_in==1`, `out_pins[opnd_q[IO_W-1:0]] <= data`.
  - This uses the store's operand, still held in `opnd_q` before that edge updates it.
  - The other output bits are unchanged.
- **Consistency check**: `seq_err` is set when `jmp_in` or `rtn_in` is high in a `state_in==0` cycle and the preceding execute edge did not act on the same opcode (non-skipped).
- **Reset**:
  - `pc_o=0`, stack empty, `stk_depth=0`, `out_pins=0`.
  - `halted`, `stk_err`, `seq_err` all 0; `op_q=NOPO`, `skip_q=0`.
  - `rst` overrides every event in the same cycle, including a mid-instruction reset. Sequencer and ICU re-align because both restart in FETCH.

## Timing
- One instruction takes two clocks.
- `pc_o` changes only at execute edges. The word at `pc_o` is stable for the whole fetch cycle.
- JMP target and RTN address are on `pc_o` in the cycle after the JMP/RTN execute edge. There is no delay slot.
- A store appears on `out_pins` one clock after the STO execute edge, i.e. at the next fetch edge.
- The input mux is combinational from `opnd_q`. Data is valid throughout the execute cycle.
- Push/pop and `stk_depth` update at the execute edge.
- Simultaneous JMP with a full stack: jump taken, depth unchanged.

## Structure
- Package `mc14500_pkg` holds:
  - the 16 opcode localparams shared with the ICU;
  - the field-slice helpers `op_of(word)` and `opnd_of(word)`.
- Sub-module `mc14500_ret_stack`:
  - parameterised LIFO (`STK_D`, `ADDR_W`) with push, pop, clear;
  - outputs: full, empty, depth, top.
- Top-level integration test wraps mc14500b + sequencer + ROM model.

## Test plan
- **Straight line.** Reset, ROM of 4 LD/STO words → `pc_o` steps 0,1,2,3 every 2 clocks; `out_pins` = 0 at reset.
- **I/O.** `in_pins=8'h20`, program LD 5; STO 2; NOPF → `out_pins[2]=1` one clock after the STO execute edge; `halted=1`; `pc_o` frozen at 2.
- **Call/return.** JMP 0x40 at address 3 → next fetch address 0x40, `stk_depth=1`. RTN at 0x40 → `pc_o=4`, word 4 skipped (`skp_in`), word 5 executes, `seq_err=0`.
- **Overflow/underflow.** `STK_D=4`, 5 nested JMPs → depth stays 4, `stk_err=1`. With the stack empty, RTN → `pc_o=0`, `stk_err=1`.
- **SKZ.** RR=0, SKZ then JMP 0x10 → the JMP is skipped, `pc_o` increments normally, stack untouched.
- **Reset and wrap.** Assert `rst` low during an execute cycle of JMP → `pc_o=0`, depth 0, all flags 0 next cycle. With `ADDR_W=4`, a run from 15 wraps to 0.
